// File: rtl/csm_seq_multiplier_pkg.sv
// Shared constants, state encoding and full-adder helper for the sequential
// carry-save multiplier.
`default_nettype none

package csm_seq_multiplier_pkg;

  localparam int CSM_WIDTH  = 26;
  localparam int CSM_PROD_W = 52;
  localparam int CSM_ITER   = 26;

  typedef enum logic [1:0] {
    CSM_IDLE    = 2'd0,
    CSM_RUN     = 2'd1,
    CSM_RESOLVE = 2'd2
  } csm_state_e;

  // Majority of three rows: the carry output of a bitwise full-adder row.
  function automatic logic [CSM_WIDTH-1:0] fa_carry(
    input logic [CSM_WIDTH-1:0] x,
    input logic [CSM_WIDTH-1:0] y,
    input logic [CSM_WIDTH-1:0] z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csm_stage_and.sv
// Partial-product stage: gates the multiplicand with one multiplier bit.
`default_nettype none

module csm_stage_and
  import csm_seq_multiplier_pkg::*;
(
  input  logic [CSM_WIDTH-1:0] a,
  input  logic                 b_bit,
  output logic [CSM_WIDTH-1:0] pp
);

  assign pp = a & {CSM_WIDTH{b_bit}};

endmodule

`default_nettype wire

// File: rtl/csm_seq_multiplier.sv
// Sequential 26x26 unsigned carry-save multiplier: one partial-product row per
// cycle into a carry-save accumulator, then a single carry-propagate add.
`default_nettype none

module csm_seq_multiplier
  import csm_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = CSM_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != CSM_WIDTH || (1 << CNT_W) < WIDTH) begin : g_bad_cfg
    $error("csm_seq_multiplier: WIDTH must be 26 and 2**CNT_W >= WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CSM_ITER - 1);

  csm_state_e       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_acc;
  logic [WIDTH-1:0] c_acc;
  logic [WIDTH-1:0] p_lo;
  logic [CNT_W-1:0] count;

  logic             mult_bit;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] fa_sum;
  logic [WIDTH-1:0] fa_cy;
  logic [WIDTH-1:0] hi_sum;

  assign mult_bit = b_reg[count];

  csm_stage_and u_stage_and (
    .a     (a_reg),
    .b_bit (mult_bit),
    .pp    (pp)
  );

  assign fa_sum = s_acc ^ c_acc ^ pp;
  assign fa_cy  = fa_carry(s_acc, c_acc, pp);
  // The remaining high half is below 2**WIDTH, so the carry-out is always 0.
  assign hi_sum = s_acc + c_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CSM_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      s_acc   <= '0;
      c_acc   <= '0;
      p_lo    <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CSM_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            s_acc <= '0;
            c_acc <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= CSM_RUN;
          end
        end
        CSM_RUN: begin
          // Bit i retires into the top of p_lo; after 26 shifts it sits at index i.
          p_lo  <= {fa_sum[0], p_lo[WIDTH-1:1]};
          s_acc <= {1'b0, fa_sum[WIDTH-1:1]};
          c_acc <= fa_cy;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            state <= CSM_RESOLVE;
          end
        end
        CSM_RESOLVE: begin
          product <= {hi_sum, p_lo};
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= CSM_IDLE;
        end
        default: begin
          state <= CSM_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csm_seq_multiplier.sv
// Self-checking bench for csm_seq_multiplier: cycle-level reference model plus
// directed vectors with hand-computed products.
`default_nettype none

module tb_csm_seq_multiplier;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [25:0] a     = '0;
  logic [25:0] b     = '0;
  logic        busy;
  logic        done;
  logic [51:0] product;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  csm_seq_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: an accepted operation finishes 27 edges after acceptance.
  int          rem = 0;
  logic [51:0] pend;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [51:0] exp_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      rem      = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_prod = '0;
    end else if (rem == 0) begin
      exp_done = 1'b0;
      if (start) begin
        pend     = {26'b0, a} * {26'b0, b};
        rem      = 27;
        exp_busy = 1'b1;
      end
    end else begin
      rem = rem - 1;
      if (rem == 0) begin
        exp_prod = pend;
        exp_done = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",    52'(busy), 52'(exp_busy));
      check("cyc_done",    52'(done), 52'(exp_done));
      check("cyc_product", product,   exp_prod);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [25:0] x, input logic [25:0] y,
                        input logic [51:0] expv, input string name);
    int lat;
    int busy_cyc;
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y;
    lat = 1; busy_cyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"},     52'(lat),      52'd28);
    check({name, "_busy_cycles"}, 52'(busy_cyc), 52'd27);
    check({name, "_product"},     product,       expv);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulses;
    logic [25:0] x;
    logic [25:0] y;

    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy",    52'(busy), 52'd0);
    check("reset_done",    52'(done), 52'd0);
    check("reset_product", product,   52'd0);
    rst = 1'b0;

    run_op(26'd3,         26'd5,         52'd15,            "mul_3x5");
    run_op(26'h3FFFFFF,   26'h3FFFFFF,   52'hFFFFFF8000001, "mul_max");
    run_op(26'h2000000,   26'd2,         52'h0000004000000, "mul_carry_hi");
    run_op(26'd0,         26'h3FFFFFF,   52'd0,             "mul_zero");

    // A second start mid-run is ignored.
    a = 26'd100; b = 26'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    lat = 1;
    repeat (9) begin @(negedge clk); lat++; end
    a = 26'd7; b = 26'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat++;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("ignore_latency", 52'(lat), 52'd28);
    check("ignore_product", product,  52'd20000);

    // Back-to-back start in the done cycle.
    run_op(26'd6, 26'd7, 52'd42, "b2b");

    // Reset during RUN discards the operation.
    a = 26'd11; b = 26'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",    52'(busy), 52'd0);
    check("abort_done",    52'(done), 52'd0);
    check("abort_product", product,   52'd0);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) pulses++; end
    check("abort_no_done", 52'(pulses), 52'd0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; a = 26'd5; b = 26'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 52'(busy), 52'd0);
    pulses = 0;
    repeat (30) begin @(negedge clk); if (done === 1'b1) pulses++; end
    check("rst_start_no_done", 52'(pulses), 52'd0);

    // Regression: walking ones then random pairs, back to back.
    for (int i = 0; i < 26; i++) begin
      x = 26'd1 << i;
      y = 26'($urandom);
      run_op(x, y, {26'b0, x} * {26'b0, y}, "walk_a");
      run_op(y, x, {26'b0, y} * {26'b0, x}, "walk_b");
    end
    for (int i = 0; i < 948; i++) begin
      x = 26'($urandom);
      y = 26'($urandom);
      run_op(x, y, {26'b0, x} * {26'b0, y}, "rand");
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
